// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared definitions for the EEPROM burst sequencer, the serial
// engine it talks to, and the bench.
//   state_t         - one-hot sequencer state encoding
//   EEPROM_ADDR_W   - engine byte-address width
//   EEPROM_ADDR_MAX - last byte address; the burst address wraps past it
package eeprom_pkg;
  localparam int unsigned EEPROM_ADDR_W = 11;
  localparam logic [EEPROM_ADDR_W-1:0] EEPROM_ADDR_MAX = 11'h7FF;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LOAD = 5'b00010,
    S_REQ  = 5'b00100,
    S_GAP  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;
endpackage

// File: rtl/eeprom_burst_ctrl_if.sv
// eeprom_burst_ctrl_if: host-side burst command / data stream bundle.
//   master - host: drives start, rd_mode, base_addr, len, wr_data, wr_valid
//   slave  - sequencer: drives wr_ready, rd_data, rd_valid, busy, done, err
interface eeprom_burst_ctrl_if #(parameter int LEN_W = 8);
  logic             start;
  logic             rd_mode;
  logic [10:0]      base_addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, rd_mode, base_addr, len, wr_data, wr_valid,
    input  wr_ready, rd_data, rd_valid, busy, done, err
  );
  modport slave (
    input  start, rd_mode, base_addr, len, wr_data, wr_valid,
    output wr_ready, rd_data, rd_valid, busy, done, err
  );
endinterface

// File: rtl/eeprom_gap_timer.sv
// eeprom_gap_timer: loadable down-counter with zero flag. Shared between the
// inter-byte gap and the ACK timeout, which never run at the same time.
//   clk, rst_n - clock, async active-low reset
//   load       - load load_val (wins over en)
//   en         - decrement, saturating at zero
//   zero       - counter is zero
module eeprom_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/eeprom_burst_ctrl.sv
// eeprom_burst_ctrl: turns one burst request into single-byte WR/RD
// handshakes with the EEPROM serial engine.
//   CLK, RESET         - clock, async active-low reset
//   host (slave)       - burst command, write stream, read strobes, status
//   WR, RD, ADDR       - byte request to engine
//   DATA               - bidirectional data bus (driven only in write REQ)
//   ACK                - engine byte-complete pulse
// Optional: `define EEPROM_ACK_TIMEOUT_EN aborts a request not ACKed within
// TMO_CYC cycles and raises sticky err.
module eeprom_burst_ctrl
  import eeprom_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 65535
) (
  input  logic                     CLK,
  input  logic                     RESET,
  eeprom_burst_ctrl_if.slave       host,
  output logic                     WR,
  output logic                     RD,
  output logic [EEPROM_ADDR_W-1:0] ADDR,
  inout  wire  [7:0]               DATA,
  input  logic                     ACK
);
  state_t                   state, state_nx;
  logic [EEPROM_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]         cnt_q;
  logic                     mode_q;
  logic [7:0]               dout_q, rdat_q;
  logic                     wr_q, rd_q, rvld_q, done_q, err_q;

  logic                     accept, ack_hit, tmo, ld_byte;
  logic                     tmr_load, tmr_en, tmr_zero;
  logic [15:0]              tmr_val;

  eeprom_gap_timer #(.W(16)) u_tmr (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    ack_hit  = 1'b0;
    tmo      = 1'b0;
    ld_byte  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = 16'(TMO_CYC);
    unique case (state)
      S_IDLE: if (host.start) begin
        accept = 1'b1;
        if (host.len == '0) state_nx = S_DONE;
        else if (host.rd_mode) begin
          state_nx = S_REQ;
          tmr_load = 1'b1;
        end
        else state_nx = S_LOAD;
      end
      S_LOAD: if (host.wr_valid) begin
        ld_byte  = 1'b1;
        state_nx = S_REQ;
        tmr_load = 1'b1;
      end
      S_REQ: begin
        if (ACK) begin
          ack_hit  = 1'b1;
          state_nx = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = 16'(GAP_CYC - 1);
        end
`ifdef EEPROM_ACK_TIMEOUT_EN
        else if (tmr_zero) begin
          tmo      = 1'b1;
          state_nx = S_DONE;
        end
        else tmr_en = 1'b1;
`endif
      end
      S_GAP: begin
        if (!tmr_zero) tmr_en = 1'b1;
        else if (cnt_q == '0) state_nx = S_DONE;
        else if (mode_q) begin
          state_nx = S_REQ;
          tmr_load = 1'b1;
        end
        else state_nx = S_LOAD;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      dout_q <= '0;
      rdat_q <= '0;
      rvld_q <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rvld_q <= 1'b0;
      // Request lines follow REQ one cycle late, and clear on the same edge
      // that leaves REQ (ACK or timeout).
      wr_q   <= (state == S_REQ) && (state_nx == S_REQ) && !mode_q;
      rd_q   <= (state == S_REQ) && (state_nx == S_REQ) &&  mode_q;
      done_q <= (state == S_DONE);
      if (accept) begin
        addr_q <= host.base_addr;
        cnt_q  <= host.len;
        mode_q <= host.rd_mode;
        err_q  <= 1'b0;
      end
      if (ld_byte) dout_q <= host.wr_data;
      if (ack_hit) begin
        addr_q <= (addr_q == EEPROM_ADDR_MAX) ? '0 : addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
        if (mode_q) begin
          rdat_q <= DATA;
          rvld_q <= 1'b1;
        end
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  // Drive is decoded from state so reset releases the bus asynchronously.
  assign DATA          = (state == S_REQ && !mode_q) ? dout_q : 8'hzz;
  assign WR            = wr_q;
  assign RD            = rd_q;
  assign ADDR          = addr_q;
  assign host.wr_ready = (state == S_LOAD);
  assign host.rd_data  = rdat_q;
  assign host.rd_valid = rvld_q;
  assign host.busy     = (state != S_IDLE);
  assign host.done     = done_q;
  assign host.err      = err_q;
endmodule

// File: tb/tb_eeprom_burst_ctrl.sv
// tb_eeprom_burst_ctrl: directed bench for eeprom_burst_ctrl with a simple
// engine model (ACK 20 cycles after WR/RD rises, read bytes from a table).
module tb_eeprom_burst_ctrl;
  import eeprom_pkg::*;

  localparam int ACK_DLY = 20;

  logic        CLK, RESET, ACK;
  logic        WR, RD;
  logic [10:0] ADDR;
  wire  [7:0]  DATA;
  logic        eng_drv;
  logic [7:0]  eng_byte;

  int checks = 0;
  int failures = 0;

  eeprom_burst_ctrl_if #(.LEN_W(8)) hif ();

  eeprom_burst_ctrl #(.LEN_W(8), .GAP_CYC(4), .TMO_CYC(100)) dut (
    .CLK (CLK), .RESET (RESET), .host (hif.slave),
    .WR (WR), .RD (RD), .ADDR (ADDR), .DATA (DATA), .ACK (ACK)
  );

  assign DATA = eng_drv ? eng_byte : 8'hzz;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Engine model and bus log
  logic [10:0] log_addr [0:63];
  logic [7:0]  log_data [0:63];
  logic        log_rd   [0:63];
  int          n_log = 0;
  logic [7:0]  rd_bytes [0:3];
  int          rd_idx = 0;
  logic        eng_noack;
  int          gap_min = 1000;

  initial begin
    int  ecnt;
    int  gap_cnt;
    bit  in_req, gap_run;
    ACK = 1'b0; eng_drv = 1'b0; eng_byte = 8'h00;
    in_req = 0; gap_run = 0; ecnt = 0; gap_cnt = 0;
    forever begin
      @(negedge CLK or negedge RESET);
      if (!RESET) begin
        ACK = 1'b0; eng_drv = 1'b0; in_req = 0; gap_run = 0;
      end else if (CLK == 1'b0) begin
        if (ACK) begin
          ACK = 1'b0; eng_drv = 1'b0; gap_run = 1; gap_cnt = 1;
        end else if (in_req) begin
          ecnt++;
          if (ecnt == ACK_DLY && !eng_noack) begin
            ACK = 1'b1; in_req = 0;
          end
        end else if (WR || RD) begin
          in_req = 1; ecnt = 0;
          if (n_log < 64) begin
            log_addr[n_log] = ADDR;
            log_data[n_log] = DATA;
            log_rd[n_log]   = RD;
          end
          n_log++;
          if (RD) begin
            eng_byte = rd_bytes[rd_idx % 4]; eng_drv = 1'b1; rd_idx++;
          end
          if (gap_run) begin
            gap_run = 0;
            if (gap_cnt < gap_min) gap_min = gap_cnt;
          end
        end else if (gap_run) gap_cnt++;
      end
    end
  end

  // Host-side monitors
  int         n_done = 0;
  int         n_rd = 0;
  logic [7:0] rd_log [0:15];
  initial forever begin
    @(negedge CLK);
    if (hif.done) n_done++;
    if (hif.rd_valid) begin
      if (n_rd < 16) rd_log[n_rd] = hif.rd_data;
      n_rd++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic rd, input logic [10:0] base, input logic [7:0] n);
    @(negedge CLK);
    hif.start = 1'b1; hif.rd_mode = rd; hif.base_addr = base; hif.len = n;
    @(negedge CLK);
    hif.start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input int hold);
    int k = 0;
    while (!hif.wr_ready && k < 300) begin @(negedge CLK); k++; end
    chk("wr_ready_wait", {31'd0, hif.wr_ready}, 32'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      chk("hold_wr_low", {31'd0, WR}, 32'd0);
      chk("hold_in_load", {31'd0, hif.wr_ready}, 32'd1);
    end
    hif.wr_data = b; hif.wr_valid = 1'b1;
    @(negedge CLK);
    hif.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (n_done == d0 && k < budget) begin @(negedge CLK); k++; end
    chk("done_seen", {31'd0, n_done > d0}, 32'd1);
  endtask

  initial begin
    int b, d0, r0, k, whi;
    RESET = 1'b0; eng_noack = 1'b0;
    hif.start = 1'b0; hif.rd_mode = 1'b0; hif.base_addr = '0; hif.len = '0;
    hif.wr_data = '0; hif.wr_valid = 1'b0;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    repeat (3) @(negedge CLK);
    chk("rst_wr",       {31'd0, WR},           32'd0);
    chk("rst_rd",       {31'd0, RD},           32'd0);
    chk("rst_addr",     {21'd0, ADDR},         32'd0);
    chk("rst_busy",     {31'd0, hif.busy},     32'd0);
    chk("rst_done",     {31'd0, hif.done},     32'd0);
    chk("rst_err",      {31'd0, hif.err},      32'd0);
    chk("rst_wr_ready", {31'd0, hif.wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, hif.rd_valid}, 32'd0);
    chk("rst_rd_data",  {24'd0, hif.rd_data},  32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Write burst 010..012
    b = n_log; d0 = n_done;
    start_burst(1'b0, 11'h010, 8'd3);
    chk("wr_busy", {31'd0, hif.busy}, 32'd1);
    feed(8'hA5, 0); feed(8'h5A, 0); feed(8'hFF, 0);
    wait_done(d0, 500);
    repeat (5) @(negedge CLK);
    chk("wr_count",   n_log - b,          32'd3);
    chk("wr_a0",      {21'd0, log_addr[b]},   32'h010);
    chk("wr_a1",      {21'd0, log_addr[b+1]}, 32'h011);
    chk("wr_a2",      {21'd0, log_addr[b+2]}, 32'h012);
    chk("wr_d0",      {24'd0, log_data[b]},   32'hA5);
    chk("wr_d1",      {24'd0, log_data[b+1]}, 32'h5A);
    chk("wr_d2",      {24'd0, log_data[b+2]}, 32'hFF);
    chk("wr_dir",     {31'd0, log_rd[b]},     32'd0);
    chk("wr_gap_min", {31'd0, gap_min >= 4},  32'd1);
    chk("wr_one_done", n_done - d0,           32'd1);
    chk("wr_err",     {31'd0, hif.err},       32'd0);
    chk("wr_idle",    {31'd0, hif.busy},      32'd0);

    // Read burst with address wrap
    b = n_log; d0 = n_done; r0 = n_rd;
    start_burst(1'b1, 11'h7FE, 8'd3);
    chk("rd_lat1_low", {31'd0, RD}, 32'd0);
    @(negedge CLK);
    chk("rd_lat2_high", {31'd0, RD}, 32'd1);
    chk("rd_lat_wr",    {31'd0, WR}, 32'd0);
    wait_done(d0, 500);
    repeat (3) @(negedge CLK);
    chk("rd_count", n_log - b, 32'd3);
    chk("rd_a0", {21'd0, log_addr[b]},   32'h7FE);
    chk("rd_a1", {21'd0, log_addr[b+1]}, 32'h7FF);
    chk("rd_a2", {21'd0, log_addr[b+2]}, 32'h000);
    chk("rd_dir", {31'd0, log_rd[b+2]},  32'd1);
    chk("rd_strobes", n_rd - r0, 32'd3);
    chk("rd_v0", {24'd0, rd_log[r0]},   32'h11);
    chk("rd_v1", {24'd0, rd_log[r0+1]}, 32'h22);
    chk("rd_v2", {24'd0, rd_log[r0+2]}, 32'h33);
    chk("rd_gap_min", {31'd0, gap_min >= 4}, 32'd1);

    // Zero-length burst
    b = n_log; d0 = n_done;
    start_burst(1'b0, 11'h123, 8'd0);
    chk("len0_busy1", {31'd0, hif.busy}, 32'd1);
    chk("len0_done1", {31'd0, hif.done}, 32'd0);
    @(negedge CLK);
    chk("len0_done2", {31'd0, hif.done}, 32'd1);
    chk("len0_busy2", {31'd0, hif.busy}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("len0_no_req", n_log - b, 32'd0);
    chk("len0_one_done", n_done - d0, 32'd1);

    // Write with wr_valid withheld before byte 2
    b = n_log; d0 = n_done;
    start_burst(1'b0, 11'h200, 8'd3);
    feed(8'h01, 0); feed(8'h02, 50); feed(8'h03, 0);
    wait_done(d0, 800);
    chk("stall_count", n_log - b, 32'd3);
    chk("stall_d0", {24'd0, log_data[b]},   32'h01);
    chk("stall_d1", {24'd0, log_data[b+1]}, 32'h02);
    chk("stall_d2", {24'd0, log_data[b+2]}, 32'h03);
    chk("stall_a2", {21'd0, log_addr[b+2]}, 32'h202);

    // Reset during REQ
    d0 = n_done;
    start_burst(1'b0, 11'h300, 8'd4);
    feed(8'hAB, 0);
    k = 0;
    while (!WR && k < 50) begin @(negedge CLK); k++; end
    chk("rstm_wr_up", {31'd0, WR}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rstm_wr",   {31'd0, WR},           32'd0);
    chk("rstm_busy", {31'd0, hif.busy},     32'd0);
    chk("rstm_addr", {21'd0, ADDR},         32'd0);
    chk("rstm_rdy",  {31'd0, hif.wr_ready}, 32'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rstm_no_done", n_done - d0, 32'd0);
    b = n_log; d0 = n_done;
    start_burst(1'b0, 11'h055, 8'd1);
    feed(8'h77, 0);
    wait_done(d0, 300);
    chk("post_count", n_log - b, 32'd1);
    chk("post_addr", {21'd0, log_addr[b]}, 32'h055);
    chk("post_data", {24'd0, log_data[b]}, 32'h77);

`ifdef EEPROM_ACK_TIMEOUT_EN
    // Engine never acknowledges: request times out
    eng_noack = 1'b1; d0 = n_done; whi = 0;
    start_burst(1'b0, 11'h100, 8'd2);
    feed(8'hC3, 0);
    k = 0;
    while (n_done == d0 && k < 400) begin
      if (WR) whi++;
      @(negedge CLK); k++;
    end
    chk("tmo_done", {31'd0, n_done > d0}, 32'd1);
    chk("tmo_wr_cycles", whi, 32'd100);
    chk("tmo_wr_low", {31'd0, WR}, 32'd0);
    chk("tmo_err", {31'd0, hif.err}, 32'd1);
    repeat (3) @(negedge CLK);
    chk("tmo_err_sticky", {31'd0, hif.err}, 32'd1);
    chk("tmo_one_done", n_done - d0, 32'd1);
    start_burst(1'b0, 11'h000, 8'd0);
    chk("tmo_err_clr", {31'd0, hif.err}, 32'd0);
    repeat (3) @(negedge CLK);
`else
    whi = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
